// File: rtl/nonce_reporter_if.sv
// Byte-stream link carrying framed nonce records out of the miner fabric.
// master drives data/valid, slave returns ready.
interface nonce_reporter_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/nonce_reporter.sv
// Captures each newly found golden nonce into a small FIFO and drains it as
// 5-byte records (0xA5 header + nonce MSB first) on a valid/ready byte stream.
module nonce_reporter #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          golden_nonce,
    nonce_reporter_if.master     tx,
    output logic [15:0]          found_count,
    output logic [7:0]           drop_count,
    output logic [AW:0]          level
);

    localparam logic [AW:0] LevelFull = (AW + 1)'(DEPTH);
    localparam logic [7:0]  Header    = 8'hA5;

    typedef enum logic {StIdle, StSend} state_e;

    state_e       state_q, state_d;
    logic [31:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]  level_q;
    logic [31:0]  last_nonce_q;
    logic [31:0]  frame_q;
    logic [2:0]   idx_q;
    logic [15:0]  found_q;
    logic [7:0]   drop_q;

    logic detect, full, handshake, last_byte, pop, push, drop, load;

    assign detect    = !rst && (golden_nonce != 32'd0) && (golden_nonce != last_nonce_q);
    assign full      = (level_q == LevelFull);
    assign handshake = (state_q == StSend) && tx.out_ready;
    assign last_byte = (idx_q == 3'd4);
    assign pop       = handshake && last_byte;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = detect && (!full || pop);
    assign drop      = detect && full && !pop;
    assign load      = (state_q == StIdle) && (level_q != '0);

    // FIFO storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= golden_nonce;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            last_nonce_q <= 32'd0;
            found_q      <= 16'd0;
            drop_q       <= 8'd0;
        end else begin
            if (detect) begin
                last_nonce_q <= golden_nonce;
                found_q      <= found_q + 16'd1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + (AW + 1)'(push) - (AW + 1)'(pop);
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Frame register holds a copy of the head so the entry can be popped
    // (and its slot refilled) on the final handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= 32'd0;
            idx_q   <= 3'd0;
        end else if (load) begin
            frame_q <= mem_q[rd_ptr_q];
            idx_q   <= 3'd0;
        end else if (handshake && !last_byte) begin
            idx_q <= idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (pop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx.out_valid = 1'b0;
        tx.out_data  = 8'h00;
        if (state_q == StSend) begin
            tx.out_valid = 1'b1;
            case (idx_q)
                3'd0:    tx.out_data = Header;
                3'd1:    tx.out_data = frame_q[31:24];
                3'd2:    tx.out_data = frame_q[23:16];
                3'd3:    tx.out_data = frame_q[15:8];
                3'd4:    tx.out_data = frame_q[7:0];
                default: tx.out_data = 8'h00;
            endcase
        end
    end

    assign found_count = found_q;
    assign drop_count  = drop_q;
    assign level       = level_q;

endmodule

// File: tb/tb_nonce_reporter.sv
// Directed bench for nonce_reporter: framing, backpressure, overflow,
// full-with-pop, repeat filtering and mid-frame reset.
module tb_nonce_reporter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] golden_nonce = 32'd0;
    logic [15:0] found_count;
    logic [7:0]  drop_count;
    logic [2:0]  level;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rx_q [$];

    logic [31:0] ov [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                            32'h44444444, 32'h55555555, 32'h66666666};
    logic [31:0] fp [5] = '{32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3,
                            32'hA4A4A4A4, 32'hA5A5A5A5};
    logic [31:0] rp_in [5]  = '{32'h5, 32'h5, 32'h0, 32'h7, 32'h5};
    logic [31:0] rp_exp [3] = '{32'h5, 32'h7, 32'h5};

    nonce_reporter_if tx_if ();

    nonce_reporter #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .golden_nonce (golden_nonce),
        .tx           (tx_if.master),
        .found_count  (found_count),
        .drop_count   (drop_count),
        .level        (level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && tx_if.out_valid && tx_if.out_ready) begin
            rx_q.push_back(tx_if.out_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] frame_byte(input logic [31:0] n, input int i);
        logic [7:0] b;
        case (i)
            0:       b = 8'hA5;
            1:       b = n[31:24];
            2:       b = n[23:16];
            3:       b = n[15:8];
            default: b = n[7:0];
        endcase
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        golden_nonce = 32'd0;
        tx_if.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (tx_if.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", tx_if.out_valid);
        end
        n_vec++;
        if (tx_if.out_data !== 8'h00) begin
            n_err++; $display("FAIL reset_data: got %h want 00", tx_if.out_data);
        end
        n_vec++;
        if (found_count !== 16'd0 || drop_count !== 8'd0 || level !== 3'd0) begin
            n_err++;
            $display("FAIL reset_counts: got found=%0d drop=%0d level=%0d want 0 0 0",
                     found_count, drop_count, level);
        end
    endtask

    task automatic test_single();
        logic [31:0] n = 32'h1234ABCD;
        do_reset();
        tx_if.out_ready = 1'b1;
        golden_nonce = n;
        step();
        n_vec++;
        if (level !== 3'd1 || found_count !== 16'd1 || tx_if.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_t1: got level=%0d found=%0d valid=%b want 1 1 0",
                     level, found_count, tx_if.out_valid);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (tx_if.out_valid !== 1'b1 || tx_if.out_data !== frame_byte(n, i)) begin
                n_err++;
                $display("FAIL single_byte%0d: got valid=%b data=%h want 1 %h",
                         i, tx_if.out_valid, tx_if.out_data, frame_byte(n, i));
            end
            step();
        end
        n_vec++;
        if (tx_if.out_valid !== 1'b0 || level !== 3'd0) begin
            n_err++;
            $display("FAIL single_bubble: got valid=%b level=%0d want 0 0",
                     tx_if.out_valid, level);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_vec++;
            if (tx_if.out_valid !== 1'b0) begin
                n_err++; $display("FAIL single_no_second: got valid=1 at idle cycle %0d want 0", i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] n = 32'h1234ABCE;
        do_reset();
        tx_if.out_ready = 1'b1;
        golden_nonce = n;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                tx_if.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    n_vec++;
                    if (tx_if.out_valid !== 1'b1 || tx_if.out_data !== 8'h34) begin
                        n_err++;
                        $display("FAIL bp_stall%0d: got valid=%b data=%h want 1 34",
                                 s, tx_if.out_valid, tx_if.out_data);
                    end
                    step();
                end
                tx_if.out_ready = 1'b1;
            end
            n_vec++;
            if (tx_if.out_valid !== 1'b1 || tx_if.out_data !== frame_byte(n, i)) begin
                n_err++;
                $display("FAIL bp_byte%0d: got valid=%b data=%h want 1 %h",
                         i, tx_if.out_valid, tx_if.out_data, frame_byte(n, i));
            end
            step();
        end
        n_vec++;
        if (tx_if.out_valid !== 1'b0 || level !== 3'd0) begin
            n_err++;
            $display("FAIL bp_end: got valid=%b level=%0d want 0 0", tx_if.out_valid, level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            golden_nonce = ov[i];
            step();
        end
        n_vec++;
        if (level !== 3'd4 || drop_count !== 8'd2 || found_count !== 16'd6) begin
            n_err++;
            $display("FAIL ovf_counts: got level=%0d drop=%0d found=%0d want 4 2 6",
                     level, drop_count, found_count);
        end
        tx_if.out_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 5; b++) begin
                n_vec++;
                if (tx_if.out_valid !== 1'b1 || tx_if.out_data !== frame_byte(ov[f], b)) begin
                    n_err++;
                    $display("FAIL ovf_f%0d_b%0d: got valid=%b data=%h want 1 %h", f, b,
                             tx_if.out_valid, tx_if.out_data, frame_byte(ov[f], b));
                end
                step();
            end
            n_vec++;
            if (tx_if.out_valid !== 1'b0 || level !== 3'(3 - f)) begin
                n_err++;
                $display("FAIL ovf_bubble%0d: got valid=%b level=%0d want 0 %0d",
                         f, tx_if.out_valid, level, 3 - f);
            end
            if (f < 3) step();
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            golden_nonce = fp[i];
            step();
        end
        rx_q.delete();
        tx_if.out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            if (b == 4) golden_nonce = fp[4];
            step();
        end
        n_vec++;
        if (level !== 3'd4 || drop_count !== 8'd0 || found_count !== 16'd5) begin
            n_err++;
            $display("FAIL fullpop_counts: got level=%0d drop=%0d found=%0d want 4 0 5",
                     level, drop_count, found_count);
        end
        repeat (40) step();
        n_vec++;
        if (rx_q.size() !== 25) begin
            n_err++; $display("FAIL fullpop_len: got %0d bytes want 25", rx_q.size());
        end else begin
            for (int k = 0; k < 25; k++) begin
                n_vec++;
                if (rx_q[k] !== frame_byte(fp[k / 5], k % 5)) begin
                    n_err++;
                    $display("FAIL fullpop_byte%0d: got %h want %h",
                             k, rx_q[k], frame_byte(fp[k / 5], k % 5));
                end
            end
        end
    endtask

    task automatic test_repeat();
        do_reset();
        rx_q.delete();
        tx_if.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            golden_nonce = rp_in[i];
            step();
        end
        repeat (30) step();
        n_vec++;
        if (found_count !== 16'd3) begin
            n_err++; $display("FAIL repeat_found: got %0d want 3", found_count);
        end
        n_vec++;
        if (rx_q.size() !== 15) begin
            n_err++; $display("FAIL repeat_len: got %0d bytes want 15", rx_q.size());
        end else begin
            for (int k = 0; k < 15; k++) begin
                n_vec++;
                if (rx_q[k] !== frame_byte(rp_exp[k / 5], k % 5)) begin
                    n_err++;
                    $display("FAIL repeat_byte%0d: got %h want %h",
                             k, rx_q[k], frame_byte(rp_exp[k / 5], k % 5));
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] n = 32'hDEADBEEF;
        do_reset();
        golden_nonce = 32'hB1B1B1B1; step();
        golden_nonce = 32'hB2B2B2B2; step();
        golden_nonce = 32'hB3B3B3B3; step();
        tx_if.out_ready = 1'b1;
        step();
        step();
        n_vec++;
        if (tx_if.out_valid !== 1'b1 || tx_if.out_data !== 8'hB1 || level !== 3'd3) begin
            n_err++;
            $display("FAIL rstmid_pre: got valid=%b data=%h level=%0d want 1 b1 3",
                     tx_if.out_valid, tx_if.out_data, level);
        end
        rst = 1'b1;
        golden_nonce = 32'd0;
        tx_if.out_ready = 1'b0;
        step();
        n_vec++;
        if (tx_if.out_valid !== 1'b0 || tx_if.out_data !== 8'h00 || level !== 3'd0 ||
            found_count !== 16'd0 || drop_count !== 8'd0) begin
            n_err++;
            $display("FAIL rstmid_post: got valid=%b data=%h level=%0d found=%0d drop=%0d want 0 00 0 0 0",
                     tx_if.out_valid, tx_if.out_data, level, found_count, drop_count);
        end
        rst = 1'b0;
        rx_q.delete();
        tx_if.out_ready = 1'b1;
        golden_nonce = n;
        repeat (12) step();
        n_vec++;
        if (rx_q.size() !== 5 || found_count !== 16'd1) begin
            n_err++;
            $display("FAIL rstmid_fresh: got %0d bytes found=%0d want 5 1", rx_q.size(), found_count);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_vec++;
                if (rx_q[k] !== frame_byte(n, k)) begin
                    n_err++;
                    $display("FAIL rstmid_byte%0d: got %h want %h", k, rx_q[k], frame_byte(n, k));
                end
            end
        end
    endtask

    initial begin
        tx_if.out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_repeat();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
